alu_pipe: RTL and testbench

- Parametrised, registered successor to the combinational data-processing ALU.
- Executes all 16 ARM data-processing opcodes with a one-cycle latency.
- Adds multi-cycle MUL/MLA through an iterative shift-add unit.
- Uses valid/ready handshakes on both input and output, and a corrected ARM flag model (shifter carry, V preservation, S-bit gating).
- Sits between operand fetch / barrel shifter and register writeback + CPSR update.

---
 rtl/alu_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe : registered ARM data-processing ALU with an iterative multiplier.
//
// Data-processing ops complete with one cycle of latency. MUL/MLA run through
// a shift-add unit that consumes MUL_STEP multiplier bits per cycle. Inputs and
// outputs use valid/ready handshakes, and the output register holds its value
// while the consumer stalls.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake (accept when both high)
//   mul, acc            multiply mode, MLA accumulate select
//   set_flags           S bit (compare ops always update flags)
//   opcode              ARM data-processing opcode (ignored when mul=1)
//   a, b, c             Rn/Rm, shifter operand/Rs, accumulate operand
//   carry_in            CPSR C
//   shifter_carry       barrel shifter carry-out (C for logical ops)
//   flags_in            current CPSR {N,Z,C,V}
//   out_valid/out_ready result handshake
//   result, nzcv        registered result and new {N,Z,C,V}
//   write_en            result is written to Rd (low for TST/TEQ/CMP/CMN)
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mul,
  input  logic             acc,
  input  logic             set_flags,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             carry_in,
  input  logic             shifter_carry,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic             write_en
);

  localparam int N_STEPS  = WIDTH / MUL_STEP;
  localparam int CNT_W    = (N_STEPS > 2) ? $clog2(N_STEPS) : 1;
  // The accept edge already performs the first step, so the counter covers
  // the remaining N_STEPS-1 steps and finishes when it reads zero.
  localparam int CNT_INIT = (N_STEPS > 1) ? N_STEPS - 2 : 0;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state, w_state_next;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_nzcv;
  logic               r_write_en;
  logic [WIDTH-1:0]   r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_mul_s;
  logic [3:0]         r_mul_fi;

  logic               w_accept, w_load, w_mul_run;
  logic [WIDTH-1:0]   w_load_res;
  logic [3:0]         w_load_flags;
  logic               w_load_we;

  // ---------------------------------------------------------------- handshake
  assign in_ready  = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign nzcv      = r_nzcv;
  assign write_en  = r_write_en;

  // ---------------------------------------------------------- data-processing
  logic [WIDTH-1:0] w_x, w_y, w_logic, w_dp_res;
  logic             w_cin, w_arith, w_is_cmp, w_dp_c, w_dp_v;
  logic [WIDTH:0]   w_sum;
  logic [3:0]       w_dp_flags;

  always_comb begin
    w_x     = a;
    w_y     = b;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_logic = '0;
    case (opcode)
      4'h0, 4'h8: w_logic = a & b;                                       // AND, TST
      4'h1, 4'h9: w_logic = a ^ b;                                       // EOR, TEQ
      4'h2, 4'hA: begin w_y = ~b; w_cin = 1'b1; w_arith = 1'b1; end      // SUB, CMP
      4'h3:       begin w_x = b; w_y = ~a; w_cin = 1'b1; w_arith = 1'b1; end // RSB
      4'h4, 4'hB: w_arith = 1'b1;                                        // ADD, CMN
      4'h5:       begin w_cin = carry_in; w_arith = 1'b1; end            // ADC
      4'h6:       begin w_y = ~b; w_cin = carry_in; w_arith = 1'b1; end  // SBC
      4'h7:       begin w_x = b; w_y = ~a; w_cin = carry_in; w_arith = 1'b1; end // RSC
      4'hC:       w_logic = a | b;                                       // ORR
      4'hD:       w_logic = b;                                           // MOV
      4'hE:       w_logic = a & ~b;                                      // BIC
      default:    w_logic = ~b;                                          // MVN
    endcase
  end

  assign w_sum    = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_dp_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
  assign w_dp_c   = w_arith ? w_sum[WIDTH] : shifter_carry;
  // Overflow: both addends share a sign that the sum does not.
  assign w_dp_v   = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                               (w_dp_res[WIDTH-1] != w_x[WIDTH-1]))
                            : flags_in[0];
  assign w_is_cmp = (opcode[3:2] == 2'b10);
  assign w_dp_flags = (set_flags || w_is_cmp)
                    ? {w_dp_res[WIDTH-1], (w_dp_res == '0), w_dp_c, w_dp_v}
                    : flags_in;

  // ----------------------------------------------------------- shift-add step
  // In IDLE the step works straight off the inputs (first step on the accept
  // edge); in MUL it works off the iteration registers.
  logic [WIDTH-1:0] w_src_acc, w_src_mcand, w_src_mplier, w_step_sum;
  logic [WIDTH-1:0] w_pp [MUL_STEP];
  logic             w_src_s;
  logic [3:0]       w_src_fi, w_mul_flags;

  assign w_src_acc    = (r_state == S_IDLE) ? (acc ? c : '0) : r_acc;
  assign w_src_mcand  = (r_state == S_IDLE) ? a : r_mcand;
  assign w_src_mplier = (r_state == S_IDLE) ? b : r_mplier;
  assign w_src_s      = (r_state == S_IDLE) ? set_flags : r_mul_s;
  assign w_src_fi     = (r_state == S_IDLE) ? flags_in : r_mul_fi;

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign w_pp[gi] = w_src_mplier[gi] ? (w_src_mcand << gi) : '0;
  end

  always_comb begin
    w_step_sum = w_src_acc;
    for (int i = 0; i < MUL_STEP; i++) w_step_sum = w_step_sum + w_pp[i];
  end

  assign w_mul_flags = w_src_s
                     ? {w_step_sum[WIDTH-1], (w_step_sum == '0), w_src_fi[1:0]}
                     : w_src_fi;

  // ------------------------------------------------------ next-state / control
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_mul_run    = 1'b0;
    w_load_res   = w_dp_res;
    w_load_flags = w_dp_flags;
    w_load_we    = !w_is_cmp;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!mul) begin
            w_load = 1'b1;
          end else if (N_STEPS == 1) begin
            w_load       = 1'b1;
            w_load_res   = w_step_sum;
            w_load_flags = w_mul_flags;
            w_load_we    = 1'b1;
          end else begin
            w_mul_run    = 1'b1;
            w_state_next = S_MUL;
            w_cnt_next   = CNT_W'(CNT_INIT);
          end
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_load       = 1'b1;
          w_load_res   = w_step_sum;
          w_load_flags = w_mul_flags;
          w_load_we    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_mul_run  = 1'b1;
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_nzcv      <= '0;
      r_write_en  <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_mul_s     <= 1'b0;
      r_mul_fi    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      // A fresh result may load in the same cycle the old one is consumed.
      r_out_valid <= w_load || (r_out_valid && !out_ready);
      if (w_load) begin
        r_result   <= w_load_res;
        r_nzcv     <= w_load_flags;
        r_write_en <= w_load_we;
      end
      if (w_mul_run) begin
        r_acc    <= w_step_sum;
        r_mcand  <= w_src_mcand << MUL_STEP;
        r_mplier <= w_src_mplier >> MUL_STEP;
      end
      if (w_accept && mul) begin
        r_mul_s  <= set_flags;
        r_mul_fi <= flags_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe : scoreboard bench for alu_pipe (WIDTH=32, MUL_STEP=1).
// The driver pushes a reference-model prediction at each accept; an
// independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
  localparam int W = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, mul = 1'b0, acc = 1'b0, set_flags = 1'b0;
  logic carry_in = 1'b0, shifter_carry = 1'b0, out_ready = 1'b1;
  logic [3:0] opcode = '0, flags_in = '0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic in_ready, out_valid, write_en;
  logic [W-1:0] result;
  logic [3:0] nzcv;

  int n_checks = 0, n_fail = 0, n_txn = 0;
  logic [36:0] sb_q [$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mul(mul), .acc(acc), .set_flags(set_flags), .opcode(opcode),
    .a(a), .b(b), .c(c), .carry_in(carry_in), .shifter_carry(shifter_carry),
    .flags_in(flags_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .nzcv(nzcv), .write_en(write_en)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned/signed arithmetic, returns {result,nzcv,we}.
  function automatic logic [36:0] model(input logic m, ac, s, input logic [3:0] op,
                                        input logic [31:0] x, y, z,
                                        input logic cin, sc, input logic [3:0] fi);
    longint unsigned ux = x, uy = y, uz = z, full;
    longint sx = $signed(x), sy = $signed(y), sres;
    longint unsigned bw;
    logic [31:0] r;
    logic cf, vf, we, upd, arith;
    logic [3:0] nf;
    bw = cin ? 0 : 1;
    cf = sc; vf = fi[0]; we = 1'b1; upd = s; arith = 1'b0; sres = 0; r = '0;
    if (m) begin
      full = ux * uy + (ac ? uz : 0);
      r = full[31:0];
      cf = fi[1]; vf = fi[0];
    end else begin
      if (op inside {4'h8, 4'h9, 4'hA, 4'hB}) begin we = 1'b0; upd = 1'b1; end
      case (op)
        4'h0, 4'h8: r = x & y;
        4'h1, 4'h9: r = x ^ y;
        4'h2, 4'hA: begin r = 32'(ux - uy); cf = (ux >= uy); sres = sx - sy; arith = 1; end
        4'h3:       begin r = 32'(uy - ux); cf = (uy >= ux); sres = sy - sx; arith = 1; end
        4'h4, 4'hB: begin full = ux + uy; r = full[31:0]; cf = full[32]; sres = sx + sy; arith = 1; end
        4'h5:       begin full = ux + uy + (cin ? 1 : 0); r = full[31:0]; cf = full[32];
                          sres = sx + sy + (cin ? 1 : 0); arith = 1; end
        4'h6:       begin r = 32'(ux - uy - bw); cf = (ux >= uy + bw);
                          sres = sx - sy - longint'(bw); arith = 1; end
        4'h7:       begin r = 32'(uy - ux - bw); cf = (uy >= ux + bw);
                          sres = sy - sx - longint'(bw); arith = 1; end
        4'hC:       r = x | y;
        4'hD:       r = y;
        4'hE:       r = x & ~y;
        default:    r = ~y;
      endcase
      if (arith) vf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    end
    nf = upd ? {r[31], (r == 32'd0), cf, vf} : fi;
    return {r, nf, we};
  endfunction

  task automatic drive(input logic m, ac, s, input logic [3:0] op,
                       input logic [31:0] x, y, z, input logic cin, sc,
                       input logic [3:0] fi);
    mul = m; acc = ac; set_flags = s; opcode = op; a = x; b = y; c = z;
    carry_in = cin; shifter_carry = sc; flags_in = fi;
  endtask

  // Offer the driven op until accepted (bounded); scramble inputs afterwards.
  task automatic accept_wait(input bit rnd, output int waited);
    bit done;
    done = 0; waited = 0; in_valid = 1'b1;
    while (!done) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      waited++;
      if (in_ready) begin
        sb_q.push_back(model(mul, acc, set_flags, opcode, a, b, c,
                             carry_in, shifter_carry, flags_in));
        done = 1;
      end
      @(posedge clk); #1;
      if (!done && waited >= 200) begin
        check("accept_timeout", 64'(waited), 64'd0);
        done = 1;
      end
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c = $urandom; flags_in = 4'($urandom);
    carry_in = 1'($urandom); shifter_carry = 1'($urandom);
    set_flags = 1'($urandom); opcode = 4'($urandom);
  endtask

  task automatic dp_check(input string name, input logic [31:0] er,
                          input logic [3:0] en, input logic ew);
    @(negedge clk);
    check(name, {out_valid, result, nzcv, write_en}, {1'b1, er, en, ew});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one scoreboard comparison per output handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      n_txn++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got output %h/%b/%b, expected no output",
                 result, nzcv, write_en);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("sb_txn", {27'd0, result, nzcv, write_en}, {27'd0, e});
        $display("txn %0d: result=%h nzcv=%b we=%b", n_txn, result, nzcv, write_en);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_bad;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {in_ready, out_valid, write_en, nzcv, result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // Directed data-processing vectors
    drive(0, 0, 1, 4'h4, 32'h7FFF_FFFF, 32'd1, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w); dp_check("add_ovf", 32'h8000_0000, 4'b1001, 1'b1);
    drive(0, 0, 1, 4'h2, 32'd5, 32'd5, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w); dp_check("sub_zero", 32'd0, 4'b0110, 1'b1);
    drive(0, 0, 1, 4'h6, 32'd5, 32'd5, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w); dp_check("sbc_borrow", 32'hFFFF_FFFF, 4'b1000, 1'b1);
    drive(0, 0, 0, 4'hA, 32'd3, 32'd4, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w); dp_check("cmp_noS", 32'hFFFF_FFFF, 4'b1000, 1'b0);
    drive(0, 0, 1, 4'hD, 32'd9, 32'd0, 32'd0, 0, 1, 4'b0001);
    accept_wait(0, w); dp_check("mov_shc", 32'd0, 4'b0111, 1'b1);
    drive(0, 0, 1, 4'h5, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0, 4'b0000);
    accept_wait(0, w); dp_check("adc_wrap", 32'd0, 4'b0110, 1'b1);
    drive(0, 0, 0, 4'h4, 32'd1, 32'd1, 32'd0, 0, 0, 4'b1010);
    accept_wait(0, w); dp_check("add_noS", 32'd2, 4'b1010, 1'b1);
    drive(0, 0, 1, 4'h3, 32'd1, 32'd0, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w); dp_check("rsb_neg", 32'hFFFF_FFFF, 4'b1000, 1'b1);

    // MLA latency and busy window
    drive(1, 1, 1, 4'h0, 32'h0001_0000, 32'h0001_0000, 32'd7, 0, 0, 4'b0011);
    accept_wait(0, w);
    n_bad = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (out_valid || in_ready) n_bad++;
    end
    check("mla_busy", 64'(n_bad), 64'd0);
    @(negedge clk);
    check("mla_done", {out_valid, result, nzcv, write_en}, {1'b1, 32'd7, 4'b0011, 1'b1});
    @(posedge clk); #1;

    // Backpressure: hold output, block next op, accept on release
    out_ready = 1'b0;
    drive(0, 0, 1, 4'h4, 32'd1, 32'd2, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w);
    drive(0, 0, 1, 4'h2, 32'd9, 32'd4, 32'd0, 0, 0, 4'b0000);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd3});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    accept_wait(0, w);
    check("bp_release_accept", 64'(w), 64'd1);
    dp_check("bp_next_sub", 32'd5, 4'b0010, 1'b1);

    // Reset during a multiply
    drive(1, 0, 1, 4'h0, 32'd123, 32'd456, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rst_mid_mul", {in_ready, out_valid, write_en, nzcv, result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(0, 0, 1, 4'h4, 32'd20, 32'd22, 32'd0, 0, 0, 4'b0000);
    accept_wait(0, w); dp_check("add_after_rst", 32'd42, 4'b0000, 1'b1);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 4'($urandom),
            rand_val(), rand_val(), rand_val(), 1'($urandom), 1'($urandom), 4'($urandom));
      accept_wait(1, w);
    end

    // Drain
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
